// File: rtl/pipe_run_checker.sv
// pipe_run_checker: run controller for the pipelined system bench.
// Counts RUN cycles, detects halt (PC stable for HALT_CYCLES samples) or
// timeout (MAX_CYCLES), then walks a loadable expectation table against data
// memory and reports done/pass/fail_count/first_fail.
// Optional build macro PIPE_CHECKER_TRACE_EN adds simulation-only trace prints
// and an error on a failing run; logic and timing are unchanged by it.
//
// Read-port timing contract: there is no valid/ready handshake on the memory
// side. In CHECK_REQ the address for a valid entry is driven combinationally
// on mem_raddr; the memory must return that word on mem_rdata during the very
// next cycle (CHECK_CMP), where it is compared. mem_raddr holds its last
// requested address in every other cycle.
module pipe_run_checker #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CHECKS  = 8,
    parameter int MAX_CYCLES  = 150,
    parameter int HALT_CYCLES = 4,
    localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int FW = $clog2(NUM_CHECKS + 1),
    localparam int HW = $clog2(HALT_CYCLES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           pc,
    input  logic                  exp_we,
    input  logic [IW-1:0]         exp_idx,
    input  logic                  exp_valid,
    input  logic [ADDR_WIDTH-1:0] exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timed_out,
    output logic [FW-1:0]         fail_count,
    output logic [IW-1:0]         first_fail,
    output logic [31:0]           cycles,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_CHECK_REQ = 3'd2,
        S_CHECK_CMP = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [31:0]           cycles_q, cycles_d;
    logic [HW-1:0]         halt_cnt_q, halt_cnt_d;
    logic [31:0]           pc_prev_q;
    logic                  timed_out_q, timed_out_d;
    logic [FW-1:0]         fail_count_q, fail_count_d;
    logic [IW-1:0]         first_fail_q, first_fail_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;

    logic [NUM_CHECKS-1:0] valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] data_q [NUM_CHECKS];

    logic [31:0] cycles_inc;
    logic        pc_same;
    logic        halt_hit;
    logic        timeout_hit;
    logic        table_open;
    logic        last_idx;

    assign cycles_inc  = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
    assign pc_same     = (pc == pc_prev_q);
    // The current sample completes HALT_CYCLES stable samples.
    assign halt_hit    = pc_same && (halt_cnt_q == HW'(HALT_CYCLES - 2));
    assign timeout_hit = (cycles_inc == 32'(MAX_CYCLES - 1));
    assign table_open  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign last_idx    = (idx_q == IW'(NUM_CHECKS - 1));

    // Expectation table: valid bits reset, payload only written while idle/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (exp_we && table_open && (int'(exp_idx) < NUM_CHECKS)) begin
            valid_q[exp_idx] <= exp_valid;
            addr_q[exp_idx]  <= exp_addr;
            data_q[exp_idx]  <= exp_data;
        end
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cycles_q     <= '0;
            halt_cnt_q   <= '0;
            pc_prev_q    <= '0;
            timed_out_q  <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            raddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cycles_q     <= cycles_d;
            halt_cnt_q   <= halt_cnt_d;
            pc_prev_q    <= pc;
            timed_out_q  <= timed_out_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            raddr_q      <= raddr_d;
        end
    end

    // Next-state logic: run monitoring, table walk and result accumulation.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cycles_d     = cycles_q;
        halt_cnt_d   = halt_cnt_q;
        timed_out_d  = timed_out_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        raddr_d      = raddr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    idx_d        = '0;
                    cycles_d     = '0;
                    halt_cnt_d   = '0;
                    timed_out_d  = 1'b0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                end
            end
            S_RUN: begin
                cycles_d   = cycles_inc;
                halt_cnt_d = pc_same ? halt_cnt_q + HW'(1) : '0;
                if (halt_hit) begin
                    state_d = S_CHECK_REQ;
                    idx_d   = '0;
                end else if (timeout_hit) begin
                    state_d     = S_CHECK_REQ;
                    idx_d       = '0;
                    timed_out_d = 1'b1;
                end
            end
            S_CHECK_REQ: begin
                if (valid_q[idx_q]) begin
                    raddr_d = addr_q[idx_q];
                    state_d = S_CHECK_CMP;
                end else if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_CHECK_CMP: begin
                if (mem_rdata != data_q[idx_q]) begin
                    fail_count_d = fail_count_q + FW'(1);
                    if (fail_count_q == '0) begin
                        first_fail_d = idx_q;
                    end
                end
                if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_CHECK_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_raddr  = ((state_q == S_CHECK_REQ) && valid_q[idx_q]) ? addr_q[idx_q] : raddr_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_CHECK_REQ) || (state_q == S_CHECK_CMP);
    assign done       = (state_q == S_DONE);
    assign pass       = done && (fail_count_q == '0) && !timed_out_q;
    assign timed_out  = timed_out_q;
    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;
    assign cycles     = cycles_q;
    assign dbg_state  = state_q;

`ifdef PIPE_CHECKER_TRACE_EN
    // Simulation trace of each compare and of the final result.
    always @(posedge clk) begin
        if (!reset && state_q == S_CHECK_CMP) begin
            $display("checker: idx=%0d addr=%0h exp=%0h act=%0h %s", idx_q, addr_q[idx_q],
                     data_q[idx_q], mem_rdata, (mem_rdata == data_q[idx_q]) ? "OK" : "FAIL");
        end
        if (!reset && state_q != S_DONE && state_d == S_DONE) begin
            $display("checker: done cycles=%0d %s fail_count=%0d", cycles_q,
                     timed_out_q ? "timeout" : "halt", fail_count_d);
            if (!((fail_count_d == '0) && !timed_out_q)) begin
                $error("ASSERT_FAIL: pipe_run_checker run did not pass");
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_run_checker.sv
// Testbench for pipe_run_checker: table-driven run scenarios plus directed
// sequences for reset-in-compare, restart from DONE and read-address trace.
module tb_pipe_run_checker;

    localparam logic [31:0] PC_BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc = PC_BASE;
    logic        exp_we = 1'b0;
    logic [2:0]  exp_idx = '0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata = '0;
    logic        busy, done, pass, timed_out;
    logic [3:0]  fail_count;
    logic [2:0]  first_fail;
    logic [31:0] cycles;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int pc_step = 0;
    int run_len = 0;

    pipe_run_checker #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_CHECKS(8),
        .MAX_CYCLES(20), .HALT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_valid(exp_valid),
        .exp_addr(exp_addr), .exp_data(exp_data),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .fail_count(fail_count), .first_fail(first_fail), .cycles(cycles),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory contents: word 3 holds the accumulation result 45.
    function automatic logic [31:0] memval(input int k);
        return (k == 3) ? 32'd45 : 32'(k * 7 + 1);
    endfunction

    // Data memory with one-cycle read latency.
    always @(posedge clk) mem_rdata <= memval(int'(mem_raddr[3:0]));

    typedef struct {
        int               run_len;
        logic [7:0]       mask;
        logic [7:0][31:0] addr;
        logic [7:0][31:0] data;
        logic             x_pass;
        logic             x_to;
        int               x_fc;
        int               x_ff;
        int               x_cycles;
        int               x_chk;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; inputs and samples move 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        pc_step++;
        pc = PC_BASE + 32'(4 * ((pc_step < run_len) ? pc_step : run_len));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_entry(input int idx, input logic v, input logic [31:0] a,
                               input logic [31:0] d);
        exp_we = 1'b1;
        exp_idx = 3'(idx);
        exp_valid = v;
        exp_addr = a;
        exp_data = d;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic load_table(input vec_t v);
        for (int i = 0; i < 8; i++) write_entry(i, v.mask[i], v.addr[i], v.data[i]);
    endtask

    task automatic do_start(input int r);
        run_len = r;
        pc_step = 0;
        pc = PC_BASE;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for done; counts cycles spent in the check states and records
    // which low address values were driven during them.
    task automatic wait_done(output int chk, output logic [15:0] seen);
        int n;
        chk = 0;
        seen = '0;
        n = 0;
        while (!done && n < 300) begin
            if (dbg_state == 3'd2 || dbg_state == 3'd3) begin
                chk++;
                seen[mem_raddr[3:0]] = 1'b1;
            end
            tick();
            n++;
        end
        check("done_wait", {31'd0, done}, 32'd1);
    endtask

    function automatic vec_t base_vec(input int r);
        vec_t v;
        v.run_len = r;
        v.mask = '0;
        for (int i = 0; i < 8; i++) begin
            v.addr[i] = 32'(i);
            v.data[i] = memval(i);
        end
        v.x_pass = 1'b1;
        v.x_to = 1'b0;
        v.x_fc = 0;
        v.x_ff = 0;
        v.x_cycles = r + 3;
        v.x_chk = 8;
        return v;
    endfunction

    initial begin
        int chk;
        logic [15:0] seen;
        vec_t v;

        // Scenario table (MAX_CYCLES=20, HALT_CYCLES=4: halt at cycles=run_len+3).
        v = base_vec(6); v.mask = 8'h01; v.addr[0] = 3; v.data[0] = 45; v.x_chk = 9;
        vecs[0] = v;
        v = base_vec(6); v.mask = 8'h07; v.addr[0] = 3; v.data[0] = 45;
        v.addr[1] = 4; v.data[1] = 7; v.addr[2] = 5; v.data[2] = 0;
        v.x_pass = 0; v.x_fc = 2; v.x_ff = 1; v.x_chk = 11;
        vecs[1] = v;
        v = base_vec(1000); v.mask = 8'h01; v.addr[0] = 3; v.data[0] = 45;
        v.x_pass = 0; v.x_to = 1; v.x_cycles = 19; v.x_chk = 9;
        vecs[2] = v;
        v = base_vec(16); v.mask = 8'hA0; v.x_chk = 10;
        vecs[3] = v;
        v = base_vec(17); v.mask = 8'h80; v.addr[7] = 4; v.data[7] = 0;
        v.x_pass = 0; v.x_to = 1; v.x_fc = 1; v.x_ff = 7; v.x_cycles = 19; v.x_chk = 9;
        vecs[4] = v;
        v = base_vec(0);
        vecs[5] = v;
        v = base_vec(2); v.mask = 8'hFF; v.data[3] = 0; v.data[6] = 5;
        v.x_pass = 0; v.x_fc = 2; v.x_ff = 3; v.x_chk = 16;
        vecs[6] = v;

        // Reset state.
        do_reset();
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_timed_out", {31'd0, timed_out}, 32'd0);
        check("rst_fail_count", 32'(fail_count), 32'd0);
        check("rst_first_fail", 32'(first_fail), 32'd0);
        check("rst_cycles", cycles, 32'd0);
        check("rst_mem_raddr", mem_raddr, 32'd0);

        // Table-driven runs.
        for (int s = 0; s < 7; s++) begin
            load_table(vecs[s]);
            do_start(vecs[s].run_len);
            check($sformatf("v%0d_busy", s), {31'd0, busy}, 32'd1);
            check($sformatf("v%0d_done_clr", s), {31'd0, done}, 32'd0);
            wait_done(chk, seen);
            check($sformatf("v%0d_pass", s), {31'd0, pass}, {31'd0, vecs[s].x_pass});
            check($sformatf("v%0d_timed_out", s), {31'd0, timed_out}, {31'd0, vecs[s].x_to});
            check($sformatf("v%0d_fail_count", s), 32'(fail_count), 32'(vecs[s].x_fc));
            check($sformatf("v%0d_first_fail", s), 32'(first_fail), 32'(vecs[s].x_ff));
            check($sformatf("v%0d_cycles", s), cycles, 32'(vecs[s].x_cycles));
            check($sformatf("v%0d_chk_cycles", s), 32'(chk), 32'(vecs[s].x_chk));
            check($sformatf("v%0d_busy_end", s), {31'd0, busy}, 32'd0);
        end

        // Restart from DONE: rewrite entry 0 in the start cycle; write in RUN ignored.
        v = base_vec(0); v.mask = 8'h01; v.addr[0] = 3; v.data[0] = 0;
        load_table(v);
        do_start(0);
        wait_done(chk, seen);
        check("rs_first_fail_count", 32'(fail_count), 32'd1);
        check("rs_first_pass", {31'd0, pass}, 32'd0);
        exp_we = 1'b1; exp_idx = 3'd0; exp_valid = 1'b1; exp_addr = 32'd3; exp_data = 32'd45;
        do_start(8);
        exp_we = 1'b0;
        check("rs_cycles_zero", cycles, 32'd0);
        check("rs_fail_count_clr", 32'(fail_count), 32'd0);
        check("rs_done_clr", {31'd0, done}, 32'd0);
        write_entry(1, 1'b1, 32'd4, 32'd0);
        wait_done(chk, seen);
        check("rs_pass", {31'd0, pass}, 32'd1);
        check("rs_fail_count", 32'(fail_count), 32'd0);
        check("rs_cycles", cycles, 32'd11);
        check("rs_chk_cycles", 32'(chk), 32'd9);

        // Reset during CHECK_CMP discards the compare and clears the table.
        v = base_vec(0); v.mask = 8'h01; v.addr[0] = 3; v.data[0] = 0;
        load_table(v);
        do_start(0);
        for (int n = 0; n < 50 && dbg_state != 3'd3; n++) tick();
        check("rc_in_cmp", 32'(dbg_state), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rc_state", 32'(dbg_state), 32'd0);
        check("rc_done", {31'd0, done}, 32'd0);
        check("rc_busy", {31'd0, busy}, 32'd0);
        check("rc_fail_count", 32'(fail_count), 32'd0);
        do_start(0);
        wait_done(chk, seen);
        check("rc_pass_empty", {31'd0, pass}, 32'd1);
        check("rc_chk_cycles", 32'(chk), 32'd8);

        // Only entries 2 and 6 valid: only their addresses reach mem_raddr.
        do_reset();
        v = base_vec(0); v.mask = 8'h44;
        for (int i = 0; i < 8; i++) v.addr[i] = 32'(i + 1);
        v.addr[2] = 10; v.data[2] = memval(10);
        v.addr[6] = 13; v.data[6] = memval(13);
        load_table(v);
        do_start(0);
        wait_done(chk, seen);
        check("sk_chk_cycles", 32'(chk), 32'd10);
        check("sk_raddr_seen", {16'd0, seen}, 32'h0000_2401);
        check("sk_pass", {31'd0, pass}, 32'd1);
        check("sk_cycles", cycles, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
